// File: rtl/code_sequencer.sv
// Message buffer and dwell-timed sequencer feeding the display decoder.
// Codes are written while idle, then replayed one per TICK_DIV cycles.
module code_sequencer #(
    parameter int DEPTH    = 8,
    parameter int TICK_DIV = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [3:0] wr_code,
    output logic       wr_ready,
    input  logic       clr,
    input  logic       start,
    input  logic       stop,
    input  logic       loop,
    output logic [3:0] code_out,
    output logic       code_valid,
    output logic       busy,
    output logic       done,
    output logic [3:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(TICK_DIV - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t        state;
    state_t        nxt_state;
    logic [3:0]    idx;
    logic [3:0]    nxt_idx;
    logic [3:0]    nxt_count;
    logic [DW-1:0] dwell;
    logic [DW-1:0] nxt_dwell;
    logic          nxt_done;
    logic          wr_acc;
    logic [3:0]    rd_code;

    logic [3:0] mem [DEPTH];

    always_comb begin
        nxt_state = state;
        nxt_idx   = idx;
        nxt_count = count;
        nxt_dwell = dwell;
        nxt_done  = 1'b0;
        wr_acc    = 1'b0;
        unique case (state)
            IDLE: begin
                if (clr) begin
                    nxt_count = 4'd0;
                end else if (wr_en && (count < 4'(DEPTH))) begin
                    wr_acc    = 1'b1;
                    nxt_count = count + 4'd1;
                end
                if (start && !clr && (nxt_count != 4'd0)) begin
                    nxt_state = RUN;
                    nxt_idx   = 4'd0;
                    nxt_dwell = '0;
                end
            end
            RUN: begin
                if (stop) begin
                    nxt_state = IDLE;
                    nxt_idx   = 4'd0;
                    nxt_dwell = '0;
                end else if (dwell == DWELL_LAST) begin
                    nxt_dwell = '0;
                    if (idx < count - 4'd1) begin
                        nxt_idx = idx + 4'd1;
                    end else if (loop) begin
                        nxt_idx = 4'd0;
                    end else begin
                        nxt_state = IDLE;
                        nxt_idx   = 4'd0;
                        nxt_done  = 1'b1;
                    end
                end else begin
                    nxt_dwell = dwell + DW'(1);
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    // Bypass the RAM when the entry being shown is written this same edge.
    always_comb begin
        rd_code = mem[nxt_idx[AW-1:0]];
        if (wr_acc && (nxt_idx == count)) begin
            rd_code = wr_code;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[count[AW-1:0]] <= wr_code;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= 4'd0;
            dwell      <= '0;
            count      <= 4'd0;
            code_out   <= 4'h0;
            code_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            wr_ready   <= 1'b1;
        end else begin
            state      <= nxt_state;
            idx        <= nxt_idx;
            dwell      <= nxt_dwell;
            count      <= nxt_count;
            code_out   <= (nxt_state == RUN) ? rd_code : 4'h0;
            code_valid <= (nxt_state == RUN);
            busy       <= (nxt_state == RUN);
            done       <= nxt_done;
            wr_ready   <= (nxt_state == IDLE) && (nxt_count < 4'(DEPTH));
        end
    end

endmodule

// File: tb/tb_code_sequencer.sv
// Bench for code_sequencer: vector table, directed corner cases, and
// random traffic against a message-queue reference model.
module tb_code_sequencer;

    localparam int TD  = 4;
    localparam int DEP = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [3:0] wr_code = 4'h0;
    logic       wr_ready;
    logic       clr = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       loop = 1'b0;
    logic [3:0] code_out;
    logic       code_valid;
    logic       busy;
    logic       done;
    logic [3:0] count;

    int checks = 0;
    int errors = 0;

    code_sequencer #(.DEPTH(DEP), .TICK_DIV(TD)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_code(wr_code),
        .wr_ready(wr_ready), .clr(clr), .start(start), .stop(stop),
        .loop(loop), .code_out(code_out), .code_valid(code_valid),
        .busy(busy), .done(done), .count(count)
    );

    always #5 clk = ~clk;

    // Reference model: the message as a queue, playback as elapsed cycles.
    logic [3:0] msg[$];
    bit         m_run  = 1'b0;
    bit         m_done = 1'b0;
    int         m_el   = 0;

    task automatic model_update();
        m_done = 1'b0;
        if (reset) begin
            msg.delete();
            m_run = 1'b0;
            m_el  = 0;
        end else if (!m_run) begin
            if (clr) msg.delete();
            else if (wr_en && msg.size() < DEP) msg.push_back(wr_code);
            if (start && !clr && msg.size() > 0) begin
                m_run = 1'b1;
                m_el  = 0;
            end
        end else begin
            if (stop) begin
                m_run = 1'b0;
            end else if ((m_el % TD == TD - 1) && (m_el / TD == msg.size() - 1)) begin
                if (loop) m_el = 0;
                else begin
                    m_run  = 1'b0;
                    m_done = 1'b1;
                end
            end else begin
                m_el++;
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        int ecode;
        ecode = m_run ? int'(msg[m_el / TD]) : 0;
        chk({tag, ".code"}, int'(code_out), ecode);
        chk({tag, ".valid"}, int'(code_valid), int'(m_run));
        chk({tag, ".busy"}, int'(busy), int'(m_run));
        chk({tag, ".done"}, int'(done), int'(m_done));
        chk({tag, ".count"}, int'(count), msg.size());
        chk({tag, ".ready"}, int'(wr_ready), int'(!m_run && msg.size() < DEP));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_in(input logic r, input logic we, input logic [3:0] wc,
                          input logic cl, input logic st, input logic sp,
                          input logic lp);
        reset = r; wr_en = we; wr_code = wc;
        clr = cl; start = st; stop = sp; loop = lp;
    endtask

    typedef struct {
        logic       rst, we;
        logic [3:0] wc;
        logic       cl, st, sp, lp;
        logic [3:0] code;
        logic       v, b, d;
        logic [3:0] cnt;
        logic       rdy;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic we,
                                input logic [3:0] wc, input logic cl,
                                input logic st, input logic sp,
                                input logic lp, input logic [3:0] code,
                                input logic v, input logic b, input logic d,
                                input logic [3:0] cnt, input logic rdy);
        vec_t t;
        t.rst = rst; t.we = we; t.wc = wc; t.cl = cl; t.st = st;
        t.sp = sp; t.lp = lp; t.code = code; t.v = v; t.b = b;
        t.d = d; t.cnt = cnt; t.rdy = rdy;
        return t;
    endfunction

    vec_t tbl[18];

    initial begin
        tbl[0] = mk(1, 0, 4'h0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 4'd0, 1);
        tbl[1] = mk(0, 1, 4'h3, 0, 0, 0, 0, 4'h0, 0, 0, 0, 4'd1, 1);
        tbl[2] = mk(0, 1, 4'h7, 0, 0, 0, 0, 4'h0, 0, 0, 0, 4'd2, 1);
        tbl[3] = mk(0, 1, 4'hB, 0, 0, 0, 0, 4'h0, 0, 0, 0, 4'd3, 1);
        tbl[4] = mk(0, 0, 4'h0, 0, 1, 0, 0, 4'h3, 1, 1, 0, 4'd3, 0);
        for (int i = 5; i < 8; i++)
            tbl[i] = mk(0, 0, 4'h0, 0, 0, 0, 0, 4'h3, 1, 1, 0, 4'd3, 0);
        for (int i = 8; i < 12; i++)
            tbl[i] = mk(0, 0, 4'h0, 0, 0, 0, 0, 4'h7, 1, 1, 0, 4'd3, 0);
        for (int i = 12; i < 16; i++)
            tbl[i] = mk(0, 0, 4'h0, 0, 0, 0, 0, 4'hB, 1, 1, 0, 4'd3, 0);
        tbl[16] = mk(0, 0, 4'h0, 0, 0, 0, 0, 4'h0, 0, 0, 1, 4'd3, 1);
        tbl[17] = mk(0, 0, 4'h0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 4'd3, 1);
        // Writes, clears and restarts while running must be ignored.
        tbl[6].we = 1'b1;
        tbl[6].wc = 4'hE;
        tbl[9].cl = 1'b1;
        tbl[13].st = 1'b1;

        @(negedge clk);
        for (int i = 0; i < 18; i++) begin
            set_in(tbl[i].rst, tbl[i].we, tbl[i].wc, tbl[i].cl,
                   tbl[i].st, tbl[i].sp, tbl[i].lp);
            step();
            chk($sformatf("tbl%0d.code", i), int'(code_out), int'(tbl[i].code));
            chk($sformatf("tbl%0d.valid", i), int'(code_valid), int'(tbl[i].v));
            chk($sformatf("tbl%0d.busy", i), int'(busy), int'(tbl[i].b));
            chk($sformatf("tbl%0d.done", i), int'(done), int'(tbl[i].d));
            chk($sformatf("tbl%0d.count", i), int'(count), int'(tbl[i].cnt));
            chk($sformatf("tbl%0d.ready", i), int'(wr_ready), int'(tbl[i].rdy));
        end

        // Looping playback, then stop.
        set_in(0, 0, 0, 0, 1, 0, 1);
        step();
        chk_model("loop_start");
        start = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk_model("loop");
        end
        stop = 1;
        step();
        chk("loop_stop.valid", int'(code_valid), 0);
        chk("loop_stop.busy", int'(busy), 0);
        chk("loop_stop.done", int'(done), 0);
        set_in(0, 0, 0, 0, 0, 0, 0);

        // Fill to DEPTH, overflow write ignored.
        clr = 1;
        step();
        clr = 0;
        for (int i = 0; i < DEP; i++) begin
            wr_en = 1; wr_code = 4'(i + 1);
            step();
            chk_model("fill");
        end
        chk("full.ready", int'(wr_ready), 0);
        wr_code = 4'hE;
        step();
        chk("overflow.count", int'(count), DEP);
        wr_en = 0; start = 1;
        step();
        start = 0;
        for (int i = 0; i < 7 * TD; i++) step();
        chk("buf7.code", int'(code_out), 8);
        for (int i = 0; i < TD + 1; i++) begin
            step();
            chk_model("full_run");
        end

        // Empty start, write+start bypass, clr beats wr_en.
        set_in(0, 0, 0, 1, 0, 0, 0);
        step();
        clr = 0; start = 1;
        step();
        chk("empty_start.busy", int'(busy), 0);
        wr_en = 1; wr_code = 4'h5;
        step();
        chk("wr_start.code", int'(code_out), 5);
        chk("wr_start.valid", int'(code_valid), 1);
        set_in(0, 0, 0, 0, 0, 1, 0);
        step();
        set_in(0, 1, 4'h6, 1, 0, 0, 0);
        step();
        chk("clr_wr.count", int'(count), 0);

        // Ignored writes in RUN, then reset mid-run.
        set_in(0, 1, 4'h4, 0, 1, 0, 0);
        step();
        set_in(0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        set_in(0, 1, 4'h9, 1, 0, 0, 0);
        step();
        chk("run_wrclr.count", int'(count), 1);
        set_in(1, 0, 0, 0, 0, 0, 0);
        step();
        chk_model("mid_reset");
        chk("mid_reset.count", int'(count), 0);
        reset = 0;
        step();
        chk("post_reset.done", int'(done), 0);

        // Stop on the final dwell cycle of a one-shot.
        set_in(0, 1, 4'h9, 0, 0, 0, 0);
        step();
        wr_code = 4'hA;
        step();
        set_in(0, 0, 0, 0, 1, 0, 0);
        step();
        start = 0;
        for (int i = 0; i < 2 * TD - 1; i++) step();
        chk("last_dwell.code", int'(code_out), 'hA);
        stop = 1;
        step();
        chk("last_stop.valid", int'(code_valid), 0);
        chk("last_stop.done", int'(done), 0);
        stop = 0;
        step();
        chk("last_stop2.done", int'(done), 0);
        chk_model("last_stop");

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            set_in(($urandom % 80) == 0, ($urandom % 3) == 0,
                   4'($urandom), ($urandom % 16) == 0,
                   ($urandom % 6) == 0, ($urandom % 25) == 0,
                   ($urandom % 2) == 0);
            step();
            chk_model("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
